multicycle_control_fsm: RTL and testbench

Main control sequencer for the multicycle datapath. It decodes the 6-bit instruction opcode, then steps the datapath through fetch, decode, execute, memory and writeback states. It drives every datapath enable, the mux selects, and the 2-bit ALU_Op consumed by the ALU decoder. It stalls on a memory ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_control_fsm_if.sv | 10 +
 rtl/multicycle_control_fsm.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake between the multicycle control sequencer and the memory port.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath control sequencer: fetch/decode/execute/memory/writeback.
// Optional jump support is enabled by defining MC_CTRL_JUMP_EN.
module multicycle_control_fsm #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      opcode,
  multicycle_control_fsm_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 branch,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic [3:0]           state
);

  localparam logic [3:0] IDLE   = 4'd15;
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [3:0] JUMP   = 4'd11;
`endif

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
`ifdef MC_CTRL_JUMP_EN
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  logic [3:0] next_state;
  logic       is_store;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      // opcode is only valid in DECODE, so remember lw/sw for MEMADR
      if (state == DECODE)
        is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH:  next_state = mem.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYP:      next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         next_state = JUMP;
`endif
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = is_store ? MEMWR : MEMRD;
      MEMRD:  next_state = mem.mem_ready ? MEMWB : MEMRD;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = mem.mem_ready ? FETCH : MEMWR;
      EXEC:   next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BRANCH: next_state = FETCH;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: next_state = FETCH;
`ifdef MC_CTRL_JUMP_EN
      JUMP:   next_state = FETCH;
`endif
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    alu_op        = '0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        alu_op      = ALU_ADD;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI: illegal_op = 1'b0;
`ifdef MC_CTRL_JUMP_EN
          OP_J:    illegal_op = 1'b0;
`endif
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.iord      = 1'b1;
        instr_done    = mem.mem_ready;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors with hand-built expectations.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       ir_write, pc_write, branch, alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic       instr_done, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_control_fsm_if mif ();

  multicycle_control_fsm #(.OP_W(6), .ALUOP_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  bit   stim_done = 1'b0;

  logic [18:0] dut_outs;
  assign dut_outs = {mif.mem_req, mif.mem_write, mif.iord, ir_write, pc_write, branch, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                     instr_done, illegal_op};

  function automatic logic [18:0] o(logic req, logic wr, logic iord, logic irw, logic pcw,
                                    logic br, logic [1:0] pcs, logic sa, logic [1:0] sb,
                                    logic [1:0] aop, logic rd, logic m2r, logic rw,
                                    logic done, logic ill);
    return {req, wr, iord, irw, pcw, br, pcs, sa, sb, aop, rd, m2r, rw, done, ill};
  endfunction

  logic [18:0] E_IDLE, E_FETCH_W, E_FETCH_R, E_DECODE, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB;
  logic [18:0] E_MEMWR_W, E_MEMWR_R, E_EXEC, E_ALUWB, E_BRANCH, E_ADDIWB, E_JUMP;

  // Drive one cycle's inputs and record what the DUT must show during that cycle.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] outs);
    exp_t e;
    rst_n = r;
    opcode = op;
    mif.mem_ready = rdy;
    e.st = st;
    e.outs = outs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (state === e.st) passed++;
      else $display("FAIL state: got %0d expected %0d at %0t", state, e.st, $time);
      total++;
      if (dut_outs === e.outs) passed++;
      else $display("FAIL outputs(state %0d): got %b expected %b at %0t", e.st, dut_outs, e.outs, $time);
    end
  end

  localparam logic [5:0] X = 6'h3f;

  initial begin
    E_IDLE    = '0;
    E_FETCH_W = o(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    E_FETCH_R = o(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,0);
    E_DECODE  = o(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,0);
    E_DEC_ILL = o(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,1);
    E_MEMADR  = o(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0);
    E_MEMRD   = o(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
    E_MEMWB   = o(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,1,0);
    E_MEMWR_W = o(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0);
    E_MEMWR_R = o(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1,0);
    E_EXEC    = o(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0);
    E_ALUWB   = o(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1,0);
    E_BRANCH  = o(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,1,0);
    E_ADDIWB  = o(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,1,0);
    E_JUMP    = o(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,1,0);

    rst_n = 1'b0;
    opcode = '0;
    mif.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, X, 1, 4'd15, E_IDLE);
    cyc(1, X, 1, 4'd15, E_IDLE);

    // lw, no stalls: 15,0,1,2,3,4
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b100011, 0, 4'd1, E_DECODE);
    cyc(1, X,         0, 4'd2, E_MEMADR);
    cyc(1, X,         1, 4'd3, E_MEMRD);
    cyc(1, X,         0, 4'd4, E_MEMWB);

    // R-type
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b000000, 0, 4'd1, E_DECODE);
    cyc(1, X,         0, 4'd6, E_EXEC);
    cyc(1, X,         0, 4'd7, E_ALUWB);

    // sw with three wait cycles in MEMWR
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b101011, 1, 4'd1, E_DECODE);
    cyc(1, X,         1, 4'd2, E_MEMADR);
    cyc(1, X,         0, 4'd5, E_MEMWR_W);
    cyc(1, X,         0, 4'd5, E_MEMWR_W);
    cyc(1, X,         0, 4'd5, E_MEMWR_W);
    cyc(1, X,         1, 4'd5, E_MEMWR_R);

    // beq
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b000100, 1, 4'd1, E_DECODE);
    cyc(1, X,         1, 4'd8, E_BRANCH);

    // addi
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b001000, 1, 4'd1, E_DECODE);
    cyc(1, X,         0, 4'd9, E_MEMADR);
    cyc(1, X,         0, 4'd10, E_ADDIWB);

    // fetch stall then illegal opcode
    cyc(1, X,         0, 4'd0, E_FETCH_W);
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b111111, 1, 4'd1, E_DEC_ILL);

    // j: decoded only when the jump feature is built in
    cyc(1, X,         1, 4'd0, E_FETCH_R);
`ifdef MC_CTRL_JUMP_EN
    cyc(1, 6'b000010, 1, 4'd1, E_DECODE);
    cyc(1, X,         1, 4'd11, E_JUMP);
`else
    cyc(1, 6'b000010, 1, 4'd1, E_DEC_ILL);
`endif

    // reset during a MEMRD wait
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b100011, 1, 4'd1, E_DECODE);
    cyc(1, X,         1, 4'd2, E_MEMADR);
    cyc(1, X,         0, 4'd3, E_MEMRD);
    cyc(0, X,         0, 4'd3, E_MEMRD);
    cyc(1, X,         0, 4'd15, E_IDLE);
    cyc(1, X,         0, 4'd0, E_FETCH_W);
    cyc(1, X,         1, 4'd0, E_FETCH_R);
    cyc(1, 6'b000100, 1, 4'd1, E_DECODE);
    cyc(1, X,         1, 4'd8, E_BRANCH);
    cyc(1, X,         0, 4'd0, E_FETCH_W);
    stim_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!(stim_done && exp_q.size() == 0) && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    if (!stim_done || exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
